// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the syscall unit: syscall code constants,
// the syscall-unit FSM state encoding and the decoded syscall kind.
package cpu_pkg;

   localparam int SYS_EXIT  = 10;
   localparam int SYS_PAUSE = 50;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PAUSE = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SC_PRINT = 2'd0,
      SC_EXIT  = 2'd1,
      SC_PAUSE = 2'd2
   } sc_kind_t;

endpackage

// File: rtl/syscall_fifo.sv
// Display FIFO for the syscall unit. Registered head (no fall-through),
// power-of-two depth with naturally wrapping pointers, and an explicit
// occupancy counter so full means level == FIFO_DEPTH.
module syscall_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          full,
   output logic                          empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // A pop frees a slot on the same edge, so a push into a full FIFO is legal then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full  = (level == LW'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign head  = mem[rd_ptr];

   // Storage array: data only, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            level <= level + LW'(1);
         end else if (do_pop && !do_push) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

// File: rtl/syscall_unit.sv
// Syscall execution unit: decodes EXIT / PAUSE / PRINT in EX, stalls the
// pipeline while a syscall cannot retire, and queues PRINT arguments into
// a display FIFO that keeps draining in every state.
// Optional feature macro SYSCALL_STATS_EN enables the saturating retired
// syscall counter on sys_count; otherwise sys_count is tied to 0.
module syscall_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          syscall_valid,
   input  logic [DATA_W-1:0]             syscall_code,
   input  logic [DATA_W-1:0]             syscall_arg,
   input  logic                          resume,
   output logic                          stall,
   output logic                          halted,
   output logic [DATA_W-1:0]             display_syscall,
   output logic                          disp_valid,
   output logic [DATA_W-1:0]             disp_data,
   input  logic                          disp_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   sys_count
);

   state_t   state_q;
   state_t   state_d;
   sc_kind_t kind;
   logic     fifo_push;
   logic     fifo_pop;
   logic     fifo_full;
   logic     fifo_empty;

   function automatic sc_kind_t decode(input logic [DATA_W-1:0] code);
      if (code == DATA_W'(SYS_EXIT)) begin
         return SC_EXIT;
      end else if (code == DATA_W'(SYS_PAUSE)) begin
         return SC_PAUSE;
      end
      return SC_PRINT;
   endfunction

   assign kind       = decode(syscall_code);
   assign disp_valid = ~fifo_empty;
   assign fifo_pop   = disp_valid & disp_ready;
   assign halted     = (state_q == ST_HALT);

   syscall_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (syscall_arg),
      .pop       (fifo_pop),
      .head      (disp_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next state, stall and PRINT acceptance; stall is purely combinational.
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      fifo_push = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (syscall_valid) begin
               case (kind)
                  SC_EXIT: begin
                     stall   = 1'b1;
                     state_d = ST_HALT;
                  end
                  SC_PAUSE: begin
                     stall   = 1'b1;
                     state_d = ST_PAUSE;
                  end
                  default: begin
                     if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                     end else begin
                        stall = 1'b1;
                     end
                  end
               endcase
            end
         end
         ST_PAUSE: begin
            stall = ~resume;
            if (resume) begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            stall = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Last accepted PRINT argument, updated on the push edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         display_syscall <= '0;
      end else if (fifo_push) begin
         display_syscall <= syscall_arg;
      end
   end

`ifdef SYSCALL_STATS_EN
   logic retire;

   // A syscall retires on PRINT acceptance, HALT entry, or the resume edge of a PAUSE.
   assign retire = fifo_push
                 | ((state_q == ST_RUN)   && (state_d == ST_HALT))
                 | ((state_q == ST_PAUSE) && (state_d == ST_RUN));

   // Saturating retired-syscall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sys_count <= '0;
      end else if (retire && (sys_count != 16'hFFFF)) begin
         sys_count <= sys_count + 16'd1;
      end
   end
`else
   assign sys_count = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: a vector table for the PRINT/PAUSE basics, hand
// sequences for FIFO full, EXIT, reset in HALT and pointer wrap, then random
// traffic compared against a queue-based reference model.
module tb_syscall_unit;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SYSCALL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          syscall_valid;
   logic [DW-1:0] syscall_code;
   logic [DW-1:0] syscall_arg;
   logic          resume;
   logic          stall;
   logic          halted;
   logic [DW-1:0] display_syscall;
   logic          disp_valid;
   logic [DW-1:0] disp_data;
   logic          disp_ready;
   logic [LW-1:0] fifo_level;
   logic [15:0]   sys_count;

   syscall_unit #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .syscall_valid   (syscall_valid),
      .syscall_code    (syscall_code),
      .syscall_arg     (syscall_arg),
      .resume          (resume),
      .stall           (stall),
      .halted          (halted),
      .display_syscall (display_syscall),
      .disp_valid      (disp_valid),
      .disp_data       (disp_data),
      .disp_ready      (disp_ready),
      .fifo_level      (fifo_level),
      .sys_count       (sys_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: mode 0 = running, 1 = paused, 2 = halted.
   int            m_mode;
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_disp;
   int            m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_q.delete();
      m_disp = '0;
      m_cnt  = 0;
   endtask

   function automatic bit m_stall();
      bit full   = (m_q.size() == DEPTH);
      bit pop    = (m_q.size() > 0) && disp_ready;
      bit is_ex  = (syscall_code == 10);
      bit is_pa  = (syscall_code == 50);
      if (m_mode == 0) return syscall_valid && (is_ex || is_pa || (full && !pop));
      if (m_mode == 1) return !resume;
      return 1'b1;
   endfunction

   function automatic int exp_cnt(input int c);
      return STATS ? c : 0;
   endfunction

   task automatic drive(input bit v, input int code, input logic [DW-1:0] arg,
                        input bit res, input bit rdy, input bit r);
      syscall_valid = v;
      syscall_code  = code;
      syscall_arg   = arg;
      resume        = res;
      disp_ready    = rdy;
      rst           = r;
   endtask

   // Advance one edge and apply the same event to the model.
   task automatic tick();
      bit            full = (m_q.size() == DEPTH);
      bit            pop  = (m_q.size() > 0) && disp_ready;
      bit            v    = syscall_valid;
      bit            res  = resume;
      bit            r    = rst;
      logic [DW-1:0] code = syscall_code;
      logic [DW-1:0] arg  = syscall_arg;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_mode == 0 && v) begin
            if (code == 10) begin
               m_mode = 2;
               if (m_cnt < 65535) m_cnt++;
            end else if (code == 50) begin
               m_mode = 1;
            end else if (!full || pop) begin
               m_q.push_back(arg);
               m_disp = arg;
               if (m_cnt < 65535) m_cnt++;
            end
         end else if (m_mode == 1 && res) begin
            m_mode = 0;
            if (m_cnt < 65535) m_cnt++;
         end
      end
      #1;
   endtask

   task automatic check_pre();
      if (!rst) chk("stall", stall, m_stall());
      chk("disp_valid_pre", disp_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("disp_data", disp_data, m_q[0]);
   endtask

   task automatic check_post();
      chk("fifo_level", fifo_level, m_q.size());
      chk("disp_valid", disp_valid, m_q.size() > 0);
      chk("halted", halted, m_mode == 2);
      chk("display_syscall", display_syscall, m_disp);
      chk("sys_count", sys_count, exp_cnt(m_cnt));
   endtask

   task automatic step(input bit v, input int code, input logic [DW-1:0] arg,
                       input bit res, input bit rdy, input bit r);
      drive(v, code, arg, res, rdy, r);
      #3;
      check_pre();
      tick();
      check_post();
   endtask

   typedef struct {
      bit            v;
      int            code;
      logic [DW-1:0] arg;
      bit            res;
      bit            rdy;
      bit            e_stall;
      int            e_level;
      bit            e_dv;
      logic [DW-1:0] e_disp;
      bit            e_halt;
      int            e_cnt;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 1,  32'h1234, 1'b0, 1'b1, 1'b0, 1, 1'b1, 32'h1234, 1'b0, 1};
      tbl[1]  = '{1'b0, 0,  32'h0,    1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[2]  = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[3]  = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[4]  = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[5]  = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[6]  = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h1234, 1'b0, 1};
      tbl[7]  = '{1'b1, 50, 32'h0,    1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h1234, 1'b0, 2};
      tbl[8]  = '{1'b1, 3,  32'hCAFE, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'hCAFE, 1'b0, 3};
      tbl[9]  = '{1'b1, 50, 32'h0,    1'b1, 1'b1, 1'b1, 0, 1'b0, 32'hCAFE, 1'b0, 3};
      tbl[10] = '{1'b1, 50, 32'h0,    1'b0, 1'b1, 1'b1, 0, 1'b0, 32'hCAFE, 1'b0, 3};
      tbl[11] = '{1'b0, 0,  32'h0,    1'b1, 1'b1, 1'b0, 0, 1'b0, 32'hCAFE, 1'b0, 4};
      tbl[12] = '{1'b1, 7,  32'hBEEF, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'hBEEF, 1'b0, 5};

      drive(0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_level", fifo_level, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_display", display_syscall, 0);
      chk("rst_halted", halted, 0);
      chk("rst_sys_count", sys_count, 0);
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("rst_stall", stall, 0);
      tick();

      // Table: PRINT, PAUSE/resume, ignored resumes.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].code, tbl[i].arg, tbl[i].res, tbl[i].rdy, 0);
         #3;
         chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
         check_pre();
         tick();
         chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_level);
         chk($sformatf("tbl%0d_dv", i), disp_valid, tbl[i].e_dv);
         chk($sformatf("tbl%0d_disp", i), display_syscall, tbl[i].e_disp);
         chk($sformatf("tbl%0d_halt", i), halted, tbl[i].e_halt);
         chk($sformatf("tbl%0d_cnt", i), sys_count, exp_cnt(tbl[i].e_cnt));
         check_post();
      end

      // Full FIFO: 9th PRINT stalls until the consumer pops, level stays at depth.
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 1, 32'h100 + i, 0, 0, 0);
      chk("full_level", fifo_level, DEPTH);
      drive(1, 1, 32'h108, 0, 0, 0);
      #3;
      chk("full_stall", stall, 1);
      check_pre();
      tick();
      check_post();
      chk("full_hold_disp", display_syscall, 32'h107);
      drive(1, 1, 32'h108, 0, 1, 0);
      #3;
      chk("full_pop_stall", stall, 0);
      check_pre();
      tick();
      check_post();
      chk("full_pop_level", fifo_level, DEPTH);
      chk("full_pop_disp", display_syscall, 32'h108);
      chk("full_pop_head", disp_data, 32'h101);
      // Keep pushing and popping at full so both pointers wrap several times.
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step(1, 1, 32'h200 + i, 0, 1, 0);
         chk("wrap_level", fifo_level, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 1, 0);
         #3;
         chk("wrap_order", disp_data, 32'h200 + 2 * DEPTH + i);
         check_pre();
         tick();
         check_post();
      end
      chk("wrap_empty", fifo_level, 0);
      // Push while empty with ready high: no fall-through, level settles at 1.
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 32'h300 + i, 0, 1, 0);
         chk("empty_pp_level", fifo_level, 1);
      end

      // EXIT with 3 queued entries: stays halted and stalled, FIFO drains in order.
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 2, 32'h401 + i, 0, 0, 0);
      drive(1, 10, 0, 0, 0, 0);
      #3;
      chk("exit_stall", stall, 1);
      check_pre();
      tick();
      check_post();
      chk("exit_halted", halted, 1);
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, $urandom, 1'($urandom_range(0, 1)), 1, 0);
         #3;
         chk("halt_stall", stall, 1);
         if (i < 3) chk("halt_drain", disp_data, 32'h401 + i);
         check_pre();
         tick();
         check_post();
         chk("halt_halted", halted, 1);
      end
      chk("halt_drained", fifo_level, 0);

      // Reset while halted with 4 queued entries, competing with push/pop/resume.
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 5, 32'h501 + i, 0, 0, 0);
      step(1, 10, 0, 0, 0, 0);
      chk("hrst_halted_before", halted, 1);
      step(1, 1, 32'h77, 1, 1, 1);
      chk("hrst_level", fifo_level, 0);
      chk("hrst_dv", disp_valid, 0);
      chk("hrst_display", display_syscall, 0);
      chk("hrst_halted", halted, 0);
      chk("hrst_count", sys_count, 0);
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("hrst_stall", stall, 0);
      tick();
      step(1, 1, 32'h55, 0, 0, 0);
      chk("hrst_print_disp", display_syscall, 32'h55);
      chk("hrst_print_level", fifo_level, 1);

      // Random traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         int            r    = $urandom_range(0, 99);
         int            code;
         logic [DW-1:0] arg  = $urandom;
         if (r < 3) code = 10;
         else if (r < 10) code = 50;
         else if ($urandom_range(0, 3) == 0) code = $urandom;
         else code = $urandom_range(0, 60);
         step($urandom_range(0, 99) < 60, code, arg,
              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
